// File: rtl/memory_stage.sv
// memory_stage: EX/MEM register, data-memory access FSM and MEM/WB register.
// Captures execute results and drives a variable-latency data memory over a
// req/ready handshake. Upstream stages stall while a request is pending.
// The stage resolves the branch and feeds writeback.
module memory_stage #(
    parameter int unsigned N       = 64,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         valid_E,
    input  logic [N-1:0] aluResult_E,
    input  logic [N-1:0] writeData_E,
    input  logic [N-1:0] PCBranch_E,
    input  logic         zero_E,
    input  logic         Branch_E,
    input  logic         MemRead_E,
    input  logic         MemWrite_E,
    input  logic         RegWrite_E,
    input  logic         MemtoReg_E,
    input  logic [4:0]   writeReg_E,
    output logic         stall_M,
    output logic         PCSrc_M,
    output logic [N-1:0] PCBranch_M,
    output logic         dm_req,
    output logic         dm_we,
    output logic [N-1:0] dm_addr,
    output logic [N-1:0] dm_wdata,
    input  logic         dm_ready,
    input  logic [N-1:0] dm_rdata,
    output logic         fault_M,
    output logic         valid_W,
    output logic         RegWrite_W,
    output logic         MemtoReg_W,
    output logic [4:0]   writeReg_W,
    output logic [N-1:0] aluResult_W,
    output logic [N-1:0] readData_W
);

    localparam int unsigned CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_ABORT = 2'd2
    } state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   count, count_next;
    logic               fault_next;

    logic               valid_M;
    logic [N-1:0]       aluResult_M;
    logic [N-1:0]       writeData_M;
    logic               zero_M;
    logic               Branch_M;
    logic               MemRead_M;
    logic               MemWrite_M;
    logic               RegWrite_M;
    logic               MemtoReg_M;
    logic [4:0]         writeReg_M;

    logic               memop;
    logic               retire;
    logic               rd_load;

    // EX/MEM pipeline register, held while the memory access is pending
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_M     <= 1'b0;
            aluResult_M <= '0;
            writeData_M <= '0;
            PCBranch_M  <= '0;
            zero_M      <= 1'b0;
            Branch_M    <= 1'b0;
            MemRead_M   <= 1'b0;
            MemWrite_M  <= 1'b0;
            RegWrite_M  <= 1'b0;
            MemtoReg_M  <= 1'b0;
            writeReg_M  <= '0;
        end else if (!stall_M) begin
            valid_M     <= valid_E;
            aluResult_M <= aluResult_E;
            writeData_M <= writeData_E;
            PCBranch_M  <= PCBranch_E;
            zero_M      <= zero_E;
            Branch_M    <= Branch_E;
            MemRead_M   <= MemRead_E;
            MemWrite_M  <= MemWrite_E;
            RegWrite_M  <= RegWrite_E;
            MemtoReg_M  <= MemtoReg_E;
            writeReg_M  <= writeReg_E;
        end
    end

    // Memory FSM state, wait counter and sticky fault flag
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            count   <= '0;
            fault_M <= 1'b0;
        end else begin
            state   <= state_next;
            count   <= count_next;
            fault_M <= fault_next;
        end
    end

    // Next-state logic plus handshake, stall and retire decode
    always_comb begin
        state_next = state;
        count_next = count;
        fault_next = fault_M;
        memop      = valid_M & (MemRead_M | MemWrite_M);
        dm_req     = memop & (state != S_ABORT);
        stall_M    = memop & ~dm_ready & (state != S_ABORT);
        retire     = valid_M & (~memop | dm_ready) & (state != S_ABORT);

        case (state)
            S_IDLE: begin
                if (memop && !dm_ready) begin
                    state_next = S_WAIT;
                    count_next = CNT_W'(1);
                end
            end
            S_WAIT: begin
                if (dm_ready) begin
                    state_next = S_IDLE;
                    count_next = '0;
                end else if (count == CNT_W'(TIMEOUT)) begin
                    state_next = S_ABORT;
                end else begin
                    count_next = count + CNT_W'(1);
                end
            end
            S_ABORT: begin
                fault_next = 1'b1;
                state_next = S_IDLE;
                count_next = '0;
            end
            default: begin
                state_next = S_IDLE;
                count_next = '0;
            end
        endcase
    end

    // Memory request payload comes straight from the held EX/MEM register
    assign dm_we    = MemWrite_M;
    assign dm_addr  = aluResult_M;
    assign dm_wdata = writeData_M;

    // Branch resolution from the EX/MEM register
    assign PCSrc_M = valid_M & Branch_M & zero_M;

    // Read data is captured only on a completed read; writes win over reads
    assign rd_load = dm_req & dm_ready & ~dm_we;

    // MEM/WB pipeline register; stall cycles become bubbles
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_W     <= 1'b0;
            RegWrite_W  <= 1'b0;
            MemtoReg_W  <= 1'b0;
            writeReg_W  <= '0;
            aluResult_W <= '0;
            readData_W  <= '0;
        end else begin
            valid_W     <= retire;
            RegWrite_W  <= retire & RegWrite_M;
            MemtoReg_W  <= MemtoReg_M;
            writeReg_W  <= writeReg_M;
            aluResult_W <= aluResult_M;
            if (rd_load) begin
                readData_W <= dm_rdata;
            end
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage with TIMEOUT=4.
module tb_memory_stage;

    localparam int unsigned N = 64;

    logic         clk = 1'b0;
    logic         reset;
    logic         valid_E;
    logic [N-1:0] aluResult_E;
    logic [N-1:0] writeData_E;
    logic [N-1:0] PCBranch_E;
    logic         zero_E;
    logic         Branch_E;
    logic         MemRead_E;
    logic         MemWrite_E;
    logic         RegWrite_E;
    logic         MemtoReg_E;
    logic [4:0]   writeReg_E;
    logic         stall_M;
    logic         PCSrc_M;
    logic [N-1:0] PCBranch_M;
    logic         dm_req;
    logic         dm_we;
    logic [N-1:0] dm_addr;
    logic [N-1:0] dm_wdata;
    logic         dm_ready;
    logic [N-1:0] dm_rdata;
    logic         fault_M;
    logic         valid_W;
    logic         RegWrite_W;
    logic         MemtoReg_W;
    logic [4:0]   writeReg_W;
    logic [N-1:0] aluResult_W;
    logic [N-1:0] readData_W;

    int n_checks = 0;
    int n_pass   = 0;

    memory_stage #(.N(N), .TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .valid_E(valid_E),
        .aluResult_E(aluResult_E), .writeData_E(writeData_E),
        .PCBranch_E(PCBranch_E), .zero_E(zero_E), .Branch_E(Branch_E),
        .MemRead_E(MemRead_E), .MemWrite_E(MemWrite_E),
        .RegWrite_E(RegWrite_E), .MemtoReg_E(MemtoReg_E),
        .writeReg_E(writeReg_E), .stall_M(stall_M), .PCSrc_M(PCSrc_M),
        .PCBranch_M(PCBranch_M), .dm_req(dm_req), .dm_we(dm_we),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_ready(dm_ready),
        .dm_rdata(dm_rdata), .fault_M(fault_M), .valid_W(valid_W),
        .RegWrite_W(RegWrite_W), .MemtoReg_W(MemtoReg_W),
        .writeReg_W(writeReg_W), .aluResult_W(aluResult_W),
        .readData_W(readData_W)
    );

    always #5 clk = ~clk;

    // Compare one observed value against its expected value
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are driven in the quiet window
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic bubble();
        valid_E     = 1'b0;
        aluResult_E = '0;
        writeData_E = '0;
        PCBranch_E  = '0;
        zero_E      = 1'b0;
        Branch_E    = 1'b0;
        MemRead_E   = 1'b0;
        MemWrite_E  = 1'b0;
        RegWrite_E  = 1'b0;
        MemtoReg_E  = 1'b0;
        writeReg_E  = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset    = 1'b1;
        dm_ready = 1'b0;
        dm_rdata = '0;
        bubble();
        tick();
        tick();
        #1;
        check("rst valid_W", 64'(valid_W), 64'd0);
        check("rst stall_M", 64'(stall_M), 64'd0);
        check("rst dm_req",  64'(dm_req),  64'd0);
        check("rst PCSrc_M", 64'(PCSrc_M), 64'd0);
        check("rst fault_M", 64'(fault_M), 64'd0);
        reset = 1'b0;

        // ADD: two edges E->W, no memory traffic
        valid_E = 1'b1; RegWrite_E = 1'b1; aluResult_E = 64'h10; writeReg_E = 5'd5;
        tick();
        bubble();
        #1;
        check("add dm_req",  64'(dm_req),  64'd0);
        check("add stall_M", 64'(stall_M), 64'd0);
        tick();
        check("add valid_W",     64'(valid_W),     64'd1);
        check("add aluResult_W", aluResult_W,      64'h10);
        check("add RegWrite_W",  64'(RegWrite_W),  64'd1);
        check("add writeReg_W",  64'(writeReg_W),  64'd5);

        // LDUR 0x40 with ready on the third request cycle
        valid_E = 1'b1; MemRead_E = 1'b1; MemtoReg_E = 1'b1; RegWrite_E = 1'b1;
        aluResult_E = 64'h40; writeReg_E = 5'd9;
        tick();
        bubble();
        #1;
        check("ld c1 dm_req",  64'(dm_req),  64'd1);
        check("ld c1 dm_we",   64'(dm_we),   64'd0);
        check("ld c1 stall_M", 64'(stall_M), 64'd1);
        check("ld c1 dm_addr", dm_addr,      64'h40);
        tick();
        #1;
        check("ld bubble1 valid_W", 64'(valid_W), 64'd0);
        check("ld c2 stall_M", 64'(stall_M), 64'd1);
        check("ld c2 dm_addr", dm_addr,      64'h40);
        tick();
        dm_ready = 1'b1; dm_rdata = 64'hDEAD;
        #1;
        check("ld bubble2 valid_W", 64'(valid_W), 64'd0);
        check("ld c3 stall_M", 64'(stall_M), 64'd0);
        check("ld c3 dm_req",  64'(dm_req),  64'd1);
        check("ld c3 dm_addr", dm_addr,      64'h40);
        tick();
        dm_ready = 1'b0; dm_rdata = '0;
        check("ld valid_W",    64'(valid_W),    64'd1);
        check("ld readData_W", readData_W,      64'hDEAD);
        check("ld MemtoReg_W", 64'(MemtoReg_W), 64'd1);
        check("ld writeReg_W", 64'(writeReg_W), 64'd9);
        check("ld RegWrite_W", 64'(RegWrite_W), 64'd1);

        // STUR 0x8 <- 0x55 completing immediately; read data must hold
        valid_E = 1'b1; MemWrite_E = 1'b1; aluResult_E = 64'h8; writeData_E = 64'h55;
        tick();
        bubble();
        dm_ready = 1'b1; dm_rdata = 64'h1234;
        #1;
        check("st dm_we",    64'(dm_we),   64'd1);
        check("st dm_req",   64'(dm_req),  64'd1);
        check("st stall_M",  64'(stall_M), 64'd0);
        check("st dm_addr",  dm_addr,      64'h8);
        check("st dm_wdata", dm_wdata,     64'h55);
        tick();
        dm_ready = 1'b0; dm_rdata = '0;
        #1;
        check("st valid_W",    64'(valid_W),    64'd1);
        check("st RegWrite_W", 64'(RegWrite_W), 64'd0);
        check("st readData_W", readData_W,      64'hDEAD);
        check("st we drop",    64'(dm_we),      64'd0);
        check("st req drop",   64'(dm_req),     64'd0);

        // CBZ taken then not taken
        valid_E = 1'b1; Branch_E = 1'b1; zero_E = 1'b1; PCBranch_E = 64'h100;
        tick();
        bubble();
        #1;
        check("cbz PCSrc_M",    64'(PCSrc_M), 64'd1);
        check("cbz PCBranch_M", PCBranch_M,   64'h100);
        tick();
        check("cbz PCSrc drop", 64'(PCSrc_M), 64'd0);
        valid_E = 1'b1; Branch_E = 1'b1; zero_E = 1'b0; PCBranch_E = 64'h200;
        tick();
        bubble();
        #1;
        check("cbnt PCSrc_M",    64'(PCSrc_M), 64'd0);
        check("cbnt PCBranch_M", PCBranch_M,   64'h200);
        tick();

        // Load that never completes: five request cycles, then abort
        valid_E = 1'b1; MemRead_E = 1'b1; RegWrite_E = 1'b1; aluResult_E = 64'h80;
        tick();
        bubble();
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("to req c%0d", i), 64'(dm_req), 64'd1);
            check($sformatf("to stall c%0d", i), 64'(stall_M), 64'd1);
            tick();
        end
        #1;
        check("to abort dm_req",  64'(dm_req),  64'd0);
        check("to abort stall_M", 64'(stall_M), 64'd0);
        valid_E = 1'b1; RegWrite_E = 1'b1; aluResult_E = 64'h20; writeReg_E = 5'd3;
        tick();
        bubble();
        #1;
        check("to no retire",  64'(valid_W), 64'd0);
        check("to fault_M",    64'(fault_M), 64'd1);
        tick();
        check("to resume valid_W",     64'(valid_W), 64'd1);
        check("to resume aluResult_W", aluResult_W,  64'h20);
        tick();
        check("to fault sticky", 64'(fault_M), 64'd1);

        // Reset while waiting on memory
        valid_E = 1'b1; MemRead_E = 1'b1; aluResult_E = 64'h90;
        tick();
        bubble();
        #1;
        check("rw dm_req", 64'(dm_req), 64'd1);
        tick();
        #1;
        check("rw wait stall", 64'(stall_M), 64'd1);
        reset = 1'b1;
        tick();
        #1;
        check("rw dm_req",  64'(dm_req),  64'd0);
        check("rw stall_M", 64'(stall_M), 64'd0);
        check("rw valid_W", 64'(valid_W), 64'd0);
        check("rw fault_M", 64'(fault_M), 64'd0);
        reset = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
